// File: rtl/ddr_pkg.sv
// Shared constants and state encoding for the cache-line to DDR UI adapter.
package ddr_pkg;

    localparam logic [2:0] CMD_WRITE  = 3'b000;
    localparam logic [2:0] CMD_READ   = 3'b001;
    localparam int         LINE_BYTES = 64;
    localparam int         BEAT_BYTES = 16;
    localparam int         BEATS      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RWAIT,
        ST_ACK
    } state_t;

endpackage

// File: rtl/ddr_line_adapter.sv
// Wishbone line slave -> four 128-bit DDR UI commands; write ack 5 cycles after request at full rate.
// Commands and write beats each hold until their own rdy; one line outstanding, one ack pulse per line.
module ddr_line_adapter
    import ddr_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int BEATS      = 4
) (
    input  logic                    clkDDR,
    input  logic                    rstn,
    input  logic [31:0]             ws_addr,
    input  logic [LINE_BYTES*8-1:0] ws_din,
    output logic [LINE_BYTES*8-1:0] ws_dout,
    input  logic [LINE_BYTES-1:0]   ws_dm,
    input  logic                    ws_cyc,
    input  logic                    ws_stb,
    input  logic                    ws_we,
    output logic                    ws_ack,
    input  logic                    init_calib_complete,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [BEAT_BYTES*8-1:0] app_wdf_data,
    output logic [BEAT_BYTES-1:0]   app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [BEAT_BYTES*8-1:0] app_rd_data,
    input  logic                    app_rd_data_valid
);

    localparam int         BW      = BEAT_BYTES * 8;
    localparam int         MW      = BEAT_BYTES;
    localparam logic [2:0] N_BEATS = 3'(BEATS);

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_cmd_cnt, r_wdf_cnt, r_rd_cnt;
    logic [2:0]              w_cmd_cnt_nxt, w_wdf_cnt_nxt, w_rd_cnt_nxt;
    logic [ADDR_WIDTH-7:0]   r_line, w_line_nxt;
    logic                    r_we, w_we_nxt;
    logic [LINE_BYTES*8-1:0] r_din, w_din_nxt;
    logic [LINE_BYTES-1:0]   r_dm, w_dm_nxt;
    logic                    w_hit, w_cmd_acc, w_wdf_acc, w_capture, w_issuing;
    logic                    w_unused;

    assign w_unused    = ^{ws_addr[31:ADDR_WIDTH], ws_addr[5:0]};
    assign app_wdf_end = app_wdf_wren;

    assign w_hit     = (r_state == ST_IDLE) & ws_cyc & ws_stb & init_calib_complete;
    assign w_cmd_acc = app_en & app_rdy;
    assign w_wdf_acc = app_wdf_wren & app_wdf_rdy;
    assign w_capture = app_rd_data_valid & (r_rd_cnt != N_BEATS) &
                       ((r_state == ST_READ) | (r_state == ST_RWAIT));
    assign w_issuing = (w_state_nxt == ST_WRITE) | (w_state_nxt == ST_READ);

    always_comb begin
        w_state_nxt   = r_state;
        w_line_nxt    = r_line;
        w_we_nxt      = r_we;
        w_din_nxt     = r_din;
        w_dm_nxt      = r_dm;
        w_cmd_cnt_nxt = r_cmd_cnt + {2'b00, w_cmd_acc};
        w_wdf_cnt_nxt = r_wdf_cnt + {2'b00, w_wdf_acc};
        w_rd_cnt_nxt  = r_rd_cnt + {2'b00, w_capture};
        case (r_state)
            ST_IDLE: begin
                w_cmd_cnt_nxt = '0;
                w_wdf_cnt_nxt = '0;
                w_rd_cnt_nxt  = '0;
                if (w_hit) begin
                    w_line_nxt  = ws_addr[ADDR_WIDTH-1:6];
                    w_we_nxt    = ws_we;
                    w_din_nxt   = ws_din;
                    w_dm_nxt    = ws_dm;
                    w_state_nxt = ws_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_cmd_cnt_nxt == N_BEATS && w_wdf_cnt_nxt == N_BEATS)
                    w_state_nxt = ST_ACK;
            end
            ST_READ: begin
                if (w_cmd_cnt_nxt == N_BEATS)
                    w_state_nxt = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (w_rd_cnt_nxt == N_BEATS)
                    w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_cmd_cnt_nxt = '0;
                w_wdf_cnt_nxt = '0;
                w_rd_cnt_nxt  = '0;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkDDR or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cmd_cnt <= '0;
            r_wdf_cnt <= '0;
            r_rd_cnt  <= '0;
            r_line    <= '0;
            r_we      <= 1'b0;
            r_din     <= '0;
            r_dm      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_cnt <= w_cmd_cnt_nxt;
            r_wdf_cnt <= w_wdf_cnt_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_line    <= w_line_nxt;
            r_we      <= w_we_nxt;
            r_din     <= w_din_nxt;
            r_dm      <= w_dm_nxt;
        end
    end

    // Outputs are registered from next-state counters so the following beat appears right after acceptance.
    always_ff @(posedge clkDDR or negedge rstn) begin
        if (!rstn) begin
            ws_ack       <= 1'b0;
            ws_dout      <= '0;
            app_en       <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else begin
            ws_ack       <= (w_state_nxt == ST_ACK);
            app_en       <= w_issuing && (w_cmd_cnt_nxt != N_BEATS);
            app_wdf_wren <= (w_state_nxt == ST_WRITE) && (w_wdf_cnt_nxt != N_BEATS);
            if (w_issuing) begin
                app_addr     <= ADDR_WIDTH'({w_line_nxt, w_cmd_cnt_nxt[1:0], 3'b000});
                app_cmd      <= w_we_nxt ? CMD_WRITE : CMD_READ;
                app_wdf_data <= w_din_nxt[BW*int'(w_wdf_cnt_nxt[1:0]) +: BW];
                app_wdf_mask <= ~w_dm_nxt[MW*int'(w_wdf_cnt_nxt[1:0]) +: MW];
            end
            if (w_capture)
                ws_dout[BW*int'(r_rd_cnt[1:0]) +: BW] <= app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr_line_adapter.sv
// Scoreboard bench for ddr_line_adapter: directed line transactions, a DDR UI responder and a decoupled monitor.
module tb_ddr_line_adapter;

    logic         clkDDR = 1'b0;
    logic         rstn;
    logic [31:0]  ws_addr = '0;
    logic [511:0] ws_din = '0;
    logic [511:0] ws_dout;
    logic [63:0]  ws_dm = '0;
    logic         ws_cyc = 1'b0, ws_stb = 1'b0, ws_we = 1'b0;
    logic         ws_ack;
    logic         init_calib_complete = 1'b1;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy = 1'b0;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;

    ddr_line_adapter dut (
        .clkDDR(clkDDR), .rstn(rstn),
        .ws_addr(ws_addr), .ws_din(ws_din), .ws_dout(ws_dout), .ws_dm(ws_dm),
        .ws_cyc(ws_cyc), .ws_stb(ws_stb), .ws_we(ws_we), .ws_ack(ws_ack),
        .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 clkDDR = ~clkDDR;

    typedef struct packed { logic [27:0] addr; logic [2:0] cmd; } cmd_t;
    typedef struct packed { logic [127:0] data; logic [15:0] mask; } wb_t;
    typedef struct packed { logic [31:0] lat; logic [511:0] dout; } ack_t;
    typedef struct packed { logic [31:0] due; logic [127:0] data; } rd_t;

    cmd_t         cmd_q[$];
    wb_t          wb_q[$];
    ack_t         ack_q[$];
    logic [127:0] ctrl_q[$];
    rd_t          due_q[$];

    int tests = 0, fails = 0;
    int cyc = 0, req_edge = 0;
    int acks_seen = 0, cmds_seen = 0, wbs_seen = 0;
    int rdy_mode = 0, stall = 0;
    logic [511:0] last_rd = '0;

    logic         prev_ack = 1'b0, prev_en_stall = 1'b0, prev_wr_stall = 1'b0;
    logic [27:0]  prev_addr = '0;
    logic [2:0]   prev_cmd = '0;
    logic [127:0] prev_wdata = '0;
    logic [15:0]  prev_mask = '0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got event/timeout, expected none", name);
    endtask

    always @(posedge clkDDR) cyc = cyc + 1;

    // Controller model: app_rdy policy plus read-data return three cycles after each accepted read.
    always @(posedge clkDDR) begin
        rd_t r;
        #1;
        case (rdy_mode)
            0: app_rdy = 1'b1;
            1: begin
                if (!app_en) begin app_rdy = 1'b0; stall = 0; end
                else if (stall == 3) begin app_rdy = 1'b1; stall = 0; end
                else begin app_rdy = 1'b0; stall++; end
            end
            default: app_rdy = (wbs_seen >= 4);
        endcase
        if (due_q.size() > 0 && int'(due_q[0].due) == cyc + 1) begin
            r = due_q.pop_front();
            app_rd_data_valid = 1'b1;
            app_rd_data = r.data;
        end else begin
            app_rd_data_valid = 1'b0;
            app_rd_data = '0;
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake or acks.
    always @(negedge clkDDR) begin
        cmd_t c;
        wb_t  w;
        ack_t a;
        rd_t  r;
        if (rstn) begin
            if (prev_ack) chk("ack_one_cycle", 512'(ws_ack), 512'(0));
            if (prev_en_stall) begin
                chk("cmd_addr_hold", 512'(app_addr), 512'(prev_addr));
                chk("cmd_hold", 512'(app_cmd), 512'(prev_cmd));
            end
            if (prev_wr_stall) begin
                chk("wdata_hold", 512'(app_wdf_data), 512'(prev_wdata));
                chk("wmask_hold", 512'(app_wdf_mask), 512'(prev_mask));
            end
            if (app_en && app_rdy) begin
                cmds_seen++;
                if (cmd_q.size() == 0) bad("unexpected_cmd");
                else begin
                    c = cmd_q.pop_front();
                    chk("app_addr", 512'(app_addr), 512'(c.addr));
                    chk("app_cmd", 512'(app_cmd), 512'(c.cmd));
                end
                if (app_cmd == 3'b001 && ctrl_q.size() > 0) begin
                    r.due  = 32'(cyc + 4);
                    r.data = ctrl_q.pop_front();
                    due_q.push_back(r);
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                wbs_seen++;
                chk("wdf_end", 512'(app_wdf_end), 512'(1));
                if (wb_q.size() == 0) bad("unexpected_wbeat");
                else begin
                    w = wb_q.pop_front();
                    chk("wdf_data", 512'(app_wdf_data), 512'(w.data));
                    chk("wdf_mask", 512'(app_wdf_mask), 512'(w.mask));
                end
            end
            if (ws_ack) begin
                acks_seen++;
                if (ack_q.size() == 0) bad("unexpected_ack");
                else begin
                    a = ack_q.pop_front();
                    chk("ack_latency", 512'(cyc - req_edge), 512'(a.lat));
                    chk("ws_dout", ws_dout, a.dout);
                end
            end
        end
        prev_ack      = ws_ack;
        prev_en_stall = app_en & ~app_rdy;
        prev_wr_stall = app_wdf_wren & ~app_wdf_rdy;
        prev_addr     = app_addr;
        prev_cmd      = app_cmd;
        prev_wdata    = app_wdf_data;
        prev_mask     = app_wdf_mask;
    end

    // base: hand-computed app_addr of beat 0; lat: edges from request sample to ack.
    task automatic issue_line(input logic we, input logic [31:0] addr, input logic [511:0] din,
                              input logic [63:0] dm, input logic [27:0] base, input int lat,
                              input logic [511:0] rd_line);
        cmd_t c;
        wb_t  w;
        ack_t a;
        for (int i = 0; i < 4; i++) begin
            c.addr = base + 28'(8 * i);
            c.cmd  = we ? 3'b000 : 3'b001;
            cmd_q.push_back(c);
            if (we) begin
                w.data = din[128*i +: 128];
                w.mask = ~dm[16*i +: 16];
                wb_q.push_back(w);
            end else begin
                ctrl_q.push_back(rd_line[128*i +: 128]);
            end
        end
        a.lat = 32'(lat);
        a.dout = we ? last_rd : rd_line;
        ack_q.push_back(a);
        if (!we) last_rd = rd_line;
        wbs_seen = 0;
        cmds_seen = 0;
        @(posedge clkDDR); #1;
        ws_addr = addr; ws_din = din; ws_dm = dm; ws_we = we;
        ws_cyc = 1'b1; ws_stb = 1'b1; init_calib_complete = 1'b1;
        req_edge = cyc + 1;
    endtask

    task automatic wait_ack();
        int start;
        start = acks_seen;
        for (int n = 0; n < 300 && acks_seen == start; n++) begin
            @(negedge clkDDR); #1;
        end
        if (acks_seen == start) bad("ack_timeout");
        @(posedge clkDDR); #1;
        ws_cyc = 1'b0; ws_stb = 1'b0;
    endtask

    initial begin
        logic [511:0] d;
        rd_t s;
        int start;
        rstn = 1'b0;
        repeat (2) @(posedge clkDDR);
        #1;
        chk("rst_ws_ack", 512'(ws_ack), 512'(0));
        chk("rst_ws_dout", ws_dout, 512'(0));
        chk("rst_app_en", 512'(app_en), 512'(0));
        chk("rst_wren", 512'(app_wdf_wren), 512'(0));
        chk("rst_wdf_end", 512'(app_wdf_end), 512'(0));
        chk("rst_app_addr", 512'(app_addr), 512'(0));
        chk("rst_app_cmd", 512'(app_cmd), 512'(0));
        chk("rst_wdf_data", 512'(app_wdf_data), 512'(0));
        chk("rst_wdf_mask", 512'(app_wdf_mask), 512'(0));
        @(negedge clkDDR) rstn = 1'b1;

        // Write, byte k = k, all bytes enabled, full rate: addr 0x820.., ack in cycle 5.
        for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
        chk("pattern_beat0", d[127:0], 512'(128'h0F0E0D0C0B0A09080706050403020100));
        rdy_mode = 0;
        issue_line(1'b1, 32'h0000_1040, d, {64{1'b1}}, 28'h820, 4, '0);
        wait_ack();

        // Read same line; beats captured at edges +4..+7.
        issue_line(1'b0, 32'h0000_1040, '0, '0, 28'h820, 7,
                   {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}});
        wait_ack();

        // Partial write, low offset bits ignored, 3 stall cycles per command; dout unchanged.
        rdy_mode = 1;
        issue_line(1'b1, 32'h0000_107F, {16{32'h1357_9BDF}}, 64'h0000_0000_0000_00FF,
                   28'h820, 16, '0);
        wait_ack();

        // Data runs ahead: app_rdy held low until all four data beats are accepted.
        rdy_mode = 2;
        issue_line(1'b1, 32'h0ABC_DEC0, {8{64'hFEDC_BA98_7654_3210}}, {64{1'b1}},
                   28'h55E_6F60, 8, '0);
        wait_ack();

        // Calibration low holds the request off; upper address bits are ignored.
        rdy_mode = 0;
        @(posedge clkDDR); #1;
        init_calib_complete = 1'b0;
        ws_addr = 32'hF000_2000; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
        repeat (6) begin
            @(negedge clkDDR); #1;
            chk("calib_no_en", 512'(app_en), 512'(0));
            chk("calib_no_ack", 512'(ws_ack), 512'(0));
        end
        issue_line(1'b0, 32'hF000_2000, '0, '0, 28'h1000, 7,
                   {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}});
        wait_ack();

        // Reset after two read commands accepted; stale returned beats must be dropped.
        issue_line(1'b0, 32'h0000_3000, '0, '0, 28'h1800, 7, {4{128'h5555_AAAA}});
        for (int n = 0; n < 50 && cmds_seen < 2; n++) begin
            @(negedge clkDDR); #1;
        end
        chk("two_cmds_before_reset", 512'(cmds_seen), 512'(2));
        @(posedge clkDDR); #2;
        rstn = 1'b0;
        cmd_q.delete(); wb_q.delete(); ack_q.delete(); ctrl_q.delete(); due_q.delete();
        ws_cyc = 1'b0; ws_stb = 1'b0;
        #1;
        chk("arst_app_en", 512'(app_en), 512'(0));
        chk("arst_app_addr", 512'(app_addr), 512'(0));
        chk("arst_app_cmd", 512'(app_cmd), 512'(0));
        chk("arst_ws_dout", ws_dout, 512'(0));
        chk("arst_ws_ack", 512'(ws_ack), 512'(0));
        repeat (3) @(posedge clkDDR);
        #2;
        rstn = 1'b1;
        last_rd = '0;
        start = acks_seen;
        s.due = 32'(cyc + 2); s.data = {4{32'hDEAD_BEEF}}; due_q.push_back(s);
        s.due = 32'(cyc + 3); s.data = {4{32'hBAD0_BAD0}}; due_q.push_back(s);
        repeat (6) @(negedge clkDDR);
        #1;
        chk("stale_no_ack", 512'(acks_seen - start), 512'(0));
        chk("stale_dout", ws_dout, 512'(0));
        issue_line(1'b0, 32'h0000_3000, '0, '0, 28'h1800, 7,
                   {128'h4, 128'h3, 128'h2, {8{16'h0101}}});
        wait_ack();

        repeat (4) @(posedge clkDDR);
        #1;
        chk("cmd_q_empty", 512'(cmd_q.size()), 512'(0));
        chk("wb_q_empty", 512'(wb_q.size()), 512'(0));
        chk("ack_q_empty", 512'(ack_q.size()), 512'(0));
        chk("due_q_empty", 512'(due_q.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "global timeout");
    end

endmodule
